status_branch_unit: RTL and testbench

STATUS_BRANCH_UNIT -- requirements
Module: status_branch_unit

---
 rtl/status_branch_unit.sv | 143 ++++++++++++++
 tb/tb_status_branch_unit.sv | 223 ++++++++++++++++++++++
 2 files changed

// File: rtl/status_branch_unit.sv
// Status/branch stage: registers ALU writeback, maintains the {C,S,Z} status
// register and the program counter, and halts in TRAP until reset.
module status_branch_unit #(
    parameter int WIDTH = 20,
    parameter int HALF  = 10
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             in_valid,
    output logic             in_ready,
    input  logic [2:0]       in_op,
    input  logic [WIDTH-1:0] in_result,
    input  logic [2:0]       in_flags,
    input  logic             in_half,
    input  logic [WIDTH-1:0] in_target,
    output logic             wb_valid,
    input  logic             wb_ready,
    output logic [WIDTH-1:0] wb_data,
    output logic [2:0]       status,
    output logic [WIDTH-1:0] pc,
    output logic             redirect,
    output logic             trapped
);

    // state | meaning
    // RUN   | accepting bundles whenever the writeback slot can take one
    // TRAP  | halted after a TRAP op; only rst returns to RUN
    typedef enum logic {
        RUN  = 1'b0,
        TRAP = 1'b1
    } state_t;

    localparam logic [2:0] OP_WB   = 3'b000;
    localparam logic [2:0] OP_JMP  = 3'b001;
    localparam logic [2:0] OP_JZ   = 3'b010;
    localparam logic [2:0] OP_JS   = 3'b011;
    localparam logic [2:0] OP_JZS  = 3'b100;
    localparam logic [2:0] OP_LSR  = 3'b101;
    localparam logic [2:0] OP_XSR  = 3'b110;
    localparam logic [2:0] OP_TRAP = 3'b111;

    localparam logic [WIDTH-1:0] HALF_MASK = {{(WIDTH-HALF){1'b0}}, {HALF{1'b1}}};
    localparam logic [WIDTH-1:0] PC_ONE    = {{(WIDTH-1){1'b0}}, 1'b1};

    state_t           state_q, state_d;
    logic [WIDTH-1:0] pc_q, pc_d;
    logic [2:0]       status_q, status_d;
    logic             wb_valid_q, wb_valid_d;
    logic [WIDTH-1:0] wb_data_q, wb_data_d;
    logic             redirect_q, redirect_d;

    logic             accept;
    logic             taken;
    logic [WIDTH-1:0] masked;

    // Reset must block acceptance even though state updates only at the edge.
    assign in_ready = !rst && (state_q == RUN) && (!wb_valid_q || wb_ready);
    assign accept   = in_valid && in_ready;
    assign masked   = in_half ? (in_result & HALF_MASK) : in_result;

    always_comb begin
        taken = 1'b0;
        case (in_op)
            OP_JMP:  taken = 1'b1;
            OP_JZ:   taken = status_q[0];
            OP_JS:   taken = status_q[1];
            OP_JZS:  taken = status_q[0] || status_q[1];
            default: taken = 1'b0;
        endcase
    end

    always_comb begin
        state_d    = state_q;
        pc_d       = pc_q;
        status_d   = status_q;
        wb_valid_d = wb_valid_q;
        wb_data_d  = wb_data_q;
        redirect_d = 1'b0;

        if (wb_valid_q && wb_ready) begin
            wb_valid_d = 1'b0;
        end

        if (accept) begin
            case (in_op)
                OP_WB: begin
                    wb_valid_d = 1'b1;
                    wb_data_d  = masked;
                    status_d   = {in_flags[2], in_flags[1], (masked == '0)};
                    pc_d       = pc_q + PC_ONE;
                end
                OP_JMP, OP_JZ, OP_JS, OP_JZS: begin
                    if (taken) begin
                        pc_d       = in_target;
                        redirect_d = 1'b1;
                    end else begin
                        pc_d = pc_q + PC_ONE;
                    end
                end
                OP_LSR: begin
                    status_d = in_result[2:0];
                    pc_d     = pc_q + PC_ONE;
                end
                OP_XSR: begin
                    status_d = status_q ^ in_result[2:0];
                    pc_d     = pc_q + PC_ONE;
                end
                OP_TRAP: begin
                    state_d = TRAP;
                end
                default: begin
                    state_d = state_q;
                end
            endcase
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q    <= RUN;
            pc_q       <= '0;
            status_q   <= '0;
            wb_valid_q <= 1'b0;
            wb_data_q  <= '0;
            redirect_q <= 1'b0;
        end else begin
            state_q    <= state_d;
            pc_q       <= pc_d;
            status_q   <= status_d;
            wb_valid_q <= wb_valid_d;
            wb_data_q  <= wb_data_d;
            redirect_q <= redirect_d;
        end
    end

    assign wb_valid = wb_valid_q;
    assign wb_data  = wb_data_q;
    assign status   = status_q;
    assign pc       = pc_q;
    assign redirect = redirect_q;
    assign trapped  = (state_q == TRAP);

endmodule

// File: tb/tb_status_branch_unit.sv
// Directed bench for status_branch_unit: writeback, backpressure, jumps,
// status ops, PC wrap, trap and reset, all against hand-computed values.
module tb_status_branch_unit;

    localparam int WIDTH = 20;
    localparam int HALF  = 10;

    localparam logic [2:0] OP_WB   = 3'b000;
    localparam logic [2:0] OP_JMP  = 3'b001;
    localparam logic [2:0] OP_JZ   = 3'b010;
    localparam logic [2:0] OP_JS   = 3'b011;
    localparam logic [2:0] OP_JZS  = 3'b100;
    localparam logic [2:0] OP_LSR  = 3'b101;
    localparam logic [2:0] OP_XSR  = 3'b110;
    localparam logic [2:0] OP_TRAP = 3'b111;

    logic             clk;
    logic             rst;
    logic             in_valid;
    logic             in_ready;
    logic [2:0]       in_op;
    logic [WIDTH-1:0] in_result;
    logic [2:0]       in_flags;
    logic             in_half;
    logic [WIDTH-1:0] in_target;
    logic             wb_valid;
    logic             wb_ready;
    logic [WIDTH-1:0] wb_data;
    logic [2:0]       status;
    logic [WIDTH-1:0] pc;
    logic             redirect;
    logic             trapped;

    int total = 0;
    int bad   = 0;

    status_branch_unit #(.WIDTH(WIDTH), .HALF(HALF)) dut (
        .clk      (clk),
        .rst      (rst),
        .in_valid (in_valid),
        .in_ready (in_ready),
        .in_op    (in_op),
        .in_result(in_result),
        .in_flags (in_flags),
        .in_half  (in_half),
        .in_target(in_target),
        .wb_valid (wb_valid),
        .wb_ready (wb_ready),
        .wb_data  (wb_data),
        .status   (status),
        .pc       (pc),
        .redirect (redirect),
        .trapped  (trapped)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        total++;
        if (got !== exp) begin
            bad++;
            $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
        end
    endtask

    // Inputs change 1 time unit after the rising edge; outputs are sampled there too.
    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic drive(input logic [2:0] op, input logic [WIDTH-1:0] res,
                         input logic [2:0] flags, input logic half,
                         input logic [WIDTH-1:0] tgt);
        in_valid  = 1'b1;
        in_op     = op;
        in_result = res;
        in_flags  = flags;
        in_half   = half;
        in_target = tgt;
    endtask

    task automatic send(input logic [2:0] op, input logic [WIDTH-1:0] res,
                        input logic [2:0] flags, input logic half,
                        input logic [WIDTH-1:0] tgt);
        drive(op, res, flags, half, tgt);
        step();
        in_valid = 1'b0;
    endtask

    initial begin
        rst       = 1'b1;
        in_valid  = 1'b0;
        in_op     = OP_WB;
        in_result = '0;
        in_flags  = '0;
        in_half   = 1'b0;
        in_target = '0;
        wb_ready  = 1'b0;
        #1;
        check("ready_in_rst", 32'(in_ready), 32'h0);
        step();
        step();
        rst = 1'b0;
        #1;
        check("rst_pc",       32'(pc),       32'h0);
        check("rst_status",   32'(status),   32'h0);
        check("rst_wbvalid",  32'(wb_valid), 32'h0);
        check("rst_wbdata",   32'(wb_data),  32'h0);
        check("rst_redirect", 32'(redirect), 32'h0);
        check("rst_trapped",  32'(trapped),  32'h0);
        check("rst_ready",    32'(in_ready), 32'h1);

        // Half-word WB: low 10 bits of 0xFFC00 are zero, so Z is recomputed as 1.
        send(OP_WB, 20'hFFC00, 3'b101, 1'b1, '0);
        check("wb_half_valid",  32'(wb_valid), 32'h1);
        check("wb_half_data",   32'(wb_data),  32'h0);
        check("wb_half_status", 32'(status),   32'h5);
        check("wb_half_pc",     32'(pc),       32'h1);
        wb_ready = 1'b1;
        step();
        check("wb_drain", 32'(wb_valid), 32'h0);
        wb_ready = 1'b0;

        // Backpressure then zero-bubble pass-through.
        send(OP_WB, 20'h00001, 3'b000, 1'b0, '0);
        check("bp_first_data", 32'(wb_data), 32'h1);
        check("bp_first_pc",   32'(pc),      32'h2);
        drive(OP_WB, 20'h00002, 3'b000, 1'b0, '0);
        #1;
        check("bp_ready_low", 32'(in_ready), 32'h0);
        step();
        check("bp_held_data", 32'(wb_data), 32'h1);
        check("bp_held_pc",   32'(pc),      32'h2);
        wb_ready = 1'b1;
        #1;
        check("bp_ready_high", 32'(in_ready), 32'h1);
        step();
        in_valid = 1'b0;
        check("bp_pass_valid",  32'(wb_valid), 32'h1);
        check("bp_pass_data",   32'(wb_data),  32'h2);
        check("bp_pass_pc",     32'(pc),       32'h3);
        check("bp_pass_status", 32'(status),   32'h0);
        step();
        check("bp_drain", 32'(wb_valid), 32'h0);
        wb_ready = 1'b0;

        // LSR sets Z, JZ taken with one-cycle redirect, JS not taken.
        send(OP_LSR, 20'h00001, 3'b000, 1'b0, '0);
        check("lsr_status", 32'(status), 32'h1);
        check("lsr_pc",     32'(pc),     32'h4);
        send(OP_JZ, '0, 3'b000, 1'b0, 20'h00040);
        check("jz_pc",       32'(pc),       32'h40);
        check("jz_redirect", 32'(redirect), 32'h1);
        step();
        check("jz_redirect_end", 32'(redirect), 32'h0);
        send(OP_JS, '0, 3'b000, 1'b0, 20'h00080);
        check("js_pc",       32'(pc),       32'h41);
        check("js_redirect", 32'(redirect), 32'h0);
        check("jmp_wbvalid", 32'(wb_valid), 32'h0);
        check("jmp_wbdata",  32'(wb_data),  32'h2);

        // XSR toggles status, JZS then taken on Z.
        send(OP_LSR, 20'h00003, 3'b000, 1'b0, '0);
        check("lsr2_status", 32'(status), 32'h3);
        send(OP_XSR, 20'h00006, 3'b000, 1'b0, '0);
        check("xsr_status", 32'(status), 32'h5);
        check("xsr_pc",     32'(pc),     32'h43);
        send(OP_JZS, '0, 3'b000, 1'b0, 20'h00010);
        check("jzs_pc",       32'(pc),       32'h10);
        check("jzs_redirect", 32'(redirect), 32'h1);

        // Half-word WB with nonzero low part: 0x12345 -> 0x00345, S from flags.
        send(OP_WB, 20'h12345, 3'b010, 1'b1, '0);
        check("wb2_data",   32'(wb_data), 32'h345);
        check("wb2_status", 32'(status),  32'h2);
        check("wb2_pc",     32'(pc),      32'h11);
        wb_ready = 1'b1;
        step();
        wb_ready = 1'b0;

        // PC wrap.
        send(OP_JMP, '0, 3'b000, 1'b0, 20'hFFFFF);
        check("wrap_jmp_pc", 32'(pc), 32'hFFFFF);
        send(OP_WB, 20'h00000, 3'b000, 1'b0, '0);
        check("wrap_pc",     32'(pc),     32'h0);
        check("wrap_status", 32'(status), 32'h1);
        wb_ready = 1'b1;
        step();
        wb_ready = 1'b0;

        // TRAP freezes everything until reset.
        send(OP_TRAP, '0, 3'b000, 1'b0, '0);
        check("trap_trapped", 32'(trapped),  32'h1);
        check("trap_pc",      32'(pc),       32'h0);
        check("trap_status",  32'(status),   32'h1);
        drive(OP_JMP, '0, 3'b000, 1'b0, 20'h00055);
        #1;
        check("trap_ready", 32'(in_ready), 32'h0);
        for (int i = 0; i < 3; i++) step();
        check("trap_pc_frozen", 32'(pc),      32'h0);
        check("trap_still",     32'(trapped), 32'h1);

        rst = 1'b1;
        #1;
        check("rst2_ready_low", 32'(in_ready), 32'h0);
        step();
        rst      = 1'b0;
        in_valid = 1'b0;
        #1;
        check("rst2_trapped",  32'(trapped),  32'h0);
        check("rst2_status",   32'(status),   32'h0);
        check("rst2_pc",       32'(pc),       32'h0);
        check("rst2_wbvalid",  32'(wb_valid), 32'h0);
        check("rst2_redirect", 32'(redirect), 32'h0);
        check("rst2_ready",    32'(in_ready), 32'h1);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
